piso_shift_ctrl: RTL and testbench

- Parametrised parallel-in/serial-out shift register for the serial-parallel multiplier datapath; next generation of the fixed 64-bit right shifter.
- Adds configurable width, selectable bit order latched at load, a bit counter, and a busy/done handshake so the multiplier controller needs no external counter.
- Feeds the serial operand into the SPM adder chain, one bit per enabled cycle.

---
 rtl/spm_pkg.sv | 14 +
 rtl/spm_bit_counter.sv | 28 ++
 rtl/piso_shift_ctrl.sv | 94 +++++++++
 tb/tb_piso_shift_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// Shared definitions for the serial-parallel multiplier datapath.
package spm_pkg;

  localparam int SPM_WIDTH = 64;

  localparam logic ORDER_LSB = 1'b0;
  localparam logic ORDER_MSB = 1'b1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

endpackage

// File: rtl/spm_bit_counter.sv
// Loadable down-counter with terminal-count flag; tc is high while the count is 1.
module spm_bit_counter
  import spm_pkg::*;
#(
  parameter  int WIDTH = SPM_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(WIDTH);
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign tc = (count == CNT_W'(1));

endmodule

// File: rtl/piso_shift_ctrl.sv
// Parallel-in/serial-out shifter with latched bit order, bit counter and busy/done handshake.
// Define PISO_SIGN_EXT_EN to fill idle shifts with the operand sign instead of zero.
module piso_shift_ctrl
  import spm_pkg::*;
#(
  parameter  int WIDTH = SPM_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic             ld,
  input  logic             shift,
  input  logic             msb_first,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bits_left
);

  state_t           state;
  logic [WIDTH-1:0] shiftreg;
  logic             order;
  logic             last_bit;
  logic             fill_bit;

  spm_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .load (ld),
    .en   ((state == SHIFT) && shift && !ld),
    .count(bits_left),
    .tc   (last_bit)
  );

`ifdef PISO_SIGN_EXT_EN
  logic sign;

  // MSB-first words already emitted their sign first, so they extend with zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign <= 1'b0;
    end else if (ld) begin
      sign <= msb_first ? 1'b0 : x[WIDTH-1];
    end
  end

  assign fill_bit = sign;
`else
  assign fill_bit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shiftreg <= '0;
      order    <= ORDER_LSB;
      out      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ld) begin
        shiftreg <= x;
        order    <= msb_first;
        out      <= 1'b0;
        busy     <= 1'b1;
        state    <= SHIFT;
      end else if (shift) begin
        unique case (state)
          SHIFT: begin
            if (order == ORDER_MSB) begin
              out      <= shiftreg[WIDTH-1];
              shiftreg <= {shiftreg[WIDTH-2:0], 1'b0};
            end else begin
              out      <= shiftreg[0];
              shiftreg <= {1'b0, shiftreg[WIDTH-1:1]};
            end
            if (last_bit) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          IDLE: out <= fill_bit;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piso_shift_ctrl.sv
// Directed bench for piso_shift_ctrl: an 8-bit instance and a default 64-bit instance.
module tb_piso_shift_ctrl;
  import spm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0]  x8 = '0;
  logic        ld8 = 1'b0, sh8 = 1'b0, m8 = 1'b0;
  logic        out8, busy8, done8;
  logic [3:0]  bl8;

  logic [63:0] x64 = '0;
  logic        ld64 = 1'b0, sh64 = 1'b0, m64 = 1'b0;
  logic        out64, busy64, done64;
  logic [6:0]  bl64;

  int checks = 0;
  int errors = 0;

  logic        fill_exp;
  logic [7:0]  pat;
  logic [63:0] pat64;

  always #5 clk = ~clk;

  piso_shift_ctrl #(
    .WIDTH(8)
  ) dut8 (
    .clk      (clk),
    .rst      (rst),
    .x        (x8),
    .ld       (ld8),
    .shift    (sh8),
    .msb_first(m8),
    .out      (out8),
    .busy     (busy8),
    .done     (done8),
    .bits_left(bl8)
  );

  piso_shift_ctrl dut64 (
    .clk      (clk),
    .rst      (rst),
    .x        (x64),
    .ld       (ld64),
    .shift    (sh64),
    .msb_first(m64),
    .out      (out64),
    .busy     (busy64),
    .done     (done64),
    .bits_left(bl64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic o, input logic b, input logic d,
                      input logic [3:0] n);
    chk({tag, ".out"}, 64'(out8), 64'(o));
    chk({tag, ".busy"}, 64'(busy8), 64'(b));
    chk({tag, ".done"}, 64'(done8), 64'(d));
    chk({tag, ".bits_left"}, 64'(bl8), 64'(n));
  endtask

  initial begin
`ifdef PISO_SIGN_EXT_EN
    fill_exp = 1'b1;
`else
    fill_exp = 1'b0;
`endif
    tick();
    tick();
    chk8("reset", 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    tick();
    chk8("post_reset", 1'b0, 1'b0, 1'b0, 4'd0);

    // LSB-first 0xB4 -> 0,0,1,0,1,1,0,1
    pat = 8'hB4;
    x8 = pat; m8 = 1'b0; ld8 = 1'b1;
    tick();
    chk8("lsb_load", 1'b0, 1'b1, 1'b0, 4'd8);
    ld8 = 1'b0; sh8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk8($sformatf("lsb_bit%0d", i), pat[i], i != 7, i == 7, 4'(7 - i));
    end
    sh8 = 1'b0;
    tick();
    chk8("lsb_done_clear", 1'b1, 1'b0, 1'b0, 4'd0);

    // MSB-first 0xB4 -> 1,0,1,1,0,1,0,0
    x8 = pat; m8 = 1'b1; ld8 = 1'b1;
    tick();
    chk8("msb_load", 1'b0, 1'b1, 1'b0, 4'd8);
    ld8 = 1'b0; m8 = 1'b0; sh8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk8($sformatf("msb_bit%0d", i), pat[7-i], i != 7, i == 7, 4'(7 - i));
    end

    // Stall mid-word, then asynchronous reset
    x8 = pat; ld8 = 1'b1; sh8 = 1'b0;
    tick();
    ld8 = 1'b0; sh8 = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk8("stall_pre", 1'b1, 1'b1, 1'b0, 4'd5);
    sh8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk8($sformatf("stall%0d", i), 1'b1, 1'b1, 1'b0, 4'd5);
    end
    rst = 1'b1;
    #1;
    chk8("async_reset", 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    #1;

    // Load has priority over shift and aborts the running word
    x8 = pat; ld8 = 1'b1;
    tick();
    ld8 = 1'b0; sh8 = 1'b1;
    tick();
    tick();
    x8 = 8'h01; ld8 = 1'b1;
    tick();
    chk8("prio_load", 1'b0, 1'b1, 1'b0, 4'd8);
    ld8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk8($sformatf("prio_bit%0d", i), i == 0, i != 7, i == 7, 4'(7 - i));
    end

    // Tail fill after a 0x80 LSB-first word
    x8 = 8'h80; ld8 = 1'b1;
    tick();
    ld8 = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk8("tail_last", 1'b1, 1'b0, 1'b1, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk8($sformatf("tail_fill%0d", i), fill_exp, 1'b0, 1'b0, 4'd0);
    end
    sh8 = 1'b0;
    tick();
    chk8("idle_hold", fill_exp, 1'b0, 1'b0, 4'd0);

    // Default 64-bit width
    pat64 = 64'h8000_0000_0000_0001;
    x64 = pat64; m64 = 1'b0; ld64 = 1'b1;
    tick();
    chk("w64_load.bits_left", 64'(bl64), 64'd64);
    chk("w64_load.busy", 64'(busy64), 64'd1);
    ld64 = 1'b0; sh64 = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      chk($sformatf("w64_bit%0d.out", i), 64'(out64), 64'(pat64[i]));
      chk($sformatf("w64_bit%0d.done", i), 64'(done64), 64'(i == 63));
    end
    chk("w64_end.busy", 64'(busy64), 64'd0);
    chk("w64_end.bits_left", 64'(bl64), 64'd0);
    sh64 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
